// File: rtl/visitor_dispatcher_pkg.sv
// rtl/visitor_dispatcher_pkg.sv - shared constants and state encodings for the visitor dispatcher
package visitor_dispatcher_pkg;

    localparam int DATA_W       = 32;
    localparam int DEF_ADDR_LEN = 12;
    localparam int DEF_N_TOWNS  = 8;
    localparam int DEF_RD_LAT   = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETTLE   = 3'd1;
    localparam logic [2:0] ST_BCAST    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == ST_SETTLE) || (st == ST_BCAST) || (st == ST_WAIT_ACK);
    endfunction

endpackage

// File: rtl/visitor_dispatcher_if.sv
// rtl/visitor_dispatcher_if.sv - broadcast bus from the dispatcher to the town compute units
interface visitor_dispatcher_if
    import visitor_dispatcher_pkg::*;
#(
    parameter int N_TOWNS  = DEF_N_TOWNS,
    parameter int ADDR_LEN = DEF_ADDR_LEN
) ();

    logic                bcast_valid;
    logic [DATA_W-1:0]   bcast_x;
    logic [DATA_W-1:0]   bcast_y;
    logic [DATA_W-1:0]   bcast_mass;
    logic [ADDR_LEN-1:0] bcast_index;
    logic [N_TOWNS-1:0]  town_ready;

    modport master (
        output bcast_valid,
        output bcast_x,
        output bcast_y,
        output bcast_mass,
        output bcast_index,
        input  town_ready
    );

    modport slave (
        input  bcast_valid,
        input  bcast_x,
        input  bcast_y,
        input  bcast_mass,
        input  bcast_index,
        output town_ready
    );

endinterface

// File: rtl/visitor_dispatcher_ack_tracker.sv
// rtl/visitor_dispatcher_ack_tracker.sv - remembers which towns have taken the held visitor
module dispatch_ack_tracker
    import visitor_dispatcher_pkg::*;
#(
    parameter int N_TOWNS = DEF_N_TOWNS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_track,
    input  logic [N_TOWNS-1:0] i_ready,
    input  logic [N_TOWNS-1:0] i_enable,
    output logic               o_all_accepted
);

    logic [N_TOWNS-1:0] r_accepted;
    logic               w_all;

    // A town counts as served if it took the visitor earlier, takes it now, or is not participating.
    assign w_all          = &(r_accepted | i_ready | ~i_enable);
    assign o_all_accepted = i_track & w_all;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_accepted <= '0;
        end else if (i_track) begin
            r_accepted <= w_all ? '0 : (r_accepted | i_ready);
        end
    end

endmodule

// File: rtl/visitor_dispatcher.sv
// rtl/visitor_dispatcher.sv - steps the visitor centre and broadcasts each visitor to the enabled towns
module visitor_dispatcher
    import visitor_dispatcher_pkg::*;
#(
    parameter int N_TOWNS  = DEF_N_TOWNS,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_LEN-1:0] i_num_visitors,
    input  logic [N_TOWNS-1:0]  i_town_enable,
    input  logic [DATA_W-1:0]   i_visitor_x,
    input  logic [DATA_W-1:0]   i_visitor_y,
    input  logic [DATA_W-1:0]   i_visitor_mass,
    input  logic [ADDR_LEN-1:0] i_visitor_index,
    input  logic                i_last_visitor,
    output logic                o_next,
    visitor_dispatcher_if.master bcast,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [31:0]         o_pass_cycles
);

    localparam int SETTLE_W = $clog2(RD_LAT + 1);

    logic [2:0]          r_state;
    logic [ADDR_LEN-1:0] r_count;
    logic [ADDR_LEN-1:0] r_sent;
    logic [N_TOWNS-1:0]  r_enable;
    logic [SETTLE_W-1:0] r_settle;
    logic                r_own_last;
    logic                r_next;
    logic                r_valid;
    logic                r_done;
    logic                r_error;
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_mass;
    logic [ADDR_LEN-1:0] r_index;
    logic [31:0]         r_cyc;
    logic [31:0]         r_pass_cycles;

    logic w_busy;
    logic w_track;
    logic w_own_last;
    logic w_all_accepted;

    assign w_busy     = is_busy_state(r_state);
    assign w_track    = (r_state == ST_WAIT_ACK);
    assign w_own_last = (r_sent == (r_count - ADDR_LEN'(1)));

    dispatch_ack_tracker #(
        .N_TOWNS (N_TOWNS)
    ) u_ack_tracker (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_track        (w_track),
        .i_ready        (bcast.town_ready),
        .i_enable       (r_enable),
        .o_all_accepted (w_all_accepted)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_sent        <= '0;
            r_enable      <= '0;
            r_settle      <= '0;
            r_own_last    <= 1'b0;
            r_next        <= 1'b0;
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_mass        <= '0;
            r_index       <= '0;
            r_cyc         <= '0;
            r_pass_cycles <= '0;
        end else begin
            r_next <= 1'b0;
            if (w_busy) begin
                r_cyc <= r_cyc + 32'd1;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        if (i_num_visitors == '0) begin
                            r_state       <= ST_DONE;
                            r_done        <= 1'b1;
                            r_cyc         <= '0;
                            r_pass_cycles <= '0;
                        end else begin
                            r_count  <= i_num_visitors;
                            r_enable <= i_town_enable;
                            r_done   <= 1'b0;
                            r_error  <= 1'b0;
                            r_sent   <= '0;
                            r_cyc    <= '0;
                            r_settle <= SETTLE_W'(RD_LAT);
                            r_state  <= ST_SETTLE;
                        end
                    end
                end

                // Covers the index register plus M10K read behind the visitor centre.
                ST_SETTLE: begin
                    r_settle <= r_settle - SETTLE_W'(1);
                    if (r_settle <= SETTLE_W'(1)) begin
                        r_state <= ST_BCAST;
                    end
                end

                ST_BCAST: begin
                    r_x        <= i_visitor_x;
                    r_y        <= i_visitor_y;
                    r_mass     <= i_visitor_mass;
                    r_index    <= i_visitor_index;
                    r_valid    <= 1'b1;
                    r_own_last <= w_own_last;
                    if ((i_visitor_index != r_sent) || (i_last_visitor != w_own_last)) begin
                        r_error <= 1'b1;
                    end
                    r_state <= ST_WAIT_ACK;
                end

                // Our own count decides the end of the pass; the upstream last flag is only cross-checked.
                ST_WAIT_ACK: begin
                    if (w_all_accepted) begin
                        r_valid <= 1'b0;
                        if (r_own_last) begin
                            r_state       <= ST_DONE;
                            r_done        <= 1'b1;
                            r_pass_cycles <= r_cyc + 32'd1;
                        end else begin
                            r_next   <= 1'b1;
                            r_sent   <= r_sent + ADDR_LEN'(1);
                            r_settle <= SETTLE_W'(RD_LAT);
                            r_state  <= ST_SETTLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_next            = r_next;
    assign o_busy            = w_busy;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_pass_cycles     = r_pass_cycles;
    assign bcast.bcast_valid = r_valid;
    assign bcast.bcast_x     = r_x;
    assign bcast.bcast_y     = r_y;
    assign bcast.bcast_mass  = r_mass;
    assign bcast.bcast_index = r_index;

endmodule
